// File: rtl/rename_map_table_3way_if.sv
// Bundle of decode, free-list, output, commit and flush signals for the 3-wide rename stage.
// master = surrounding pipeline, slave = rename map table.
interface rename_map_table_3way_if #(
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 64
);
    localparam int AREG_W = $clog2(ARCH_REGS);
    localparam int PTAG_W = $clog2(PHYS_REGS);

    logic [2:0]             dec_valid;
    logic [2:0][AREG_W-1:0] rs1;
    logic [2:0][AREG_W-1:0] rs2;
    logic [2:0][AREG_W-1:0] rd;
    logic [2:0]             rd_we;
    logic                   dec_ready;

    logic [PTAG_W:0]        fl_count;
    logic [2:0]             alloc_req;
    logic [2:0][PTAG_W-1:0] alloc_tag;

    // out_valid/out_ready: the group transfers on a cycle where both are high;
    // while out_valid is high and out_ready low, every out_* field is held.
    logic                   out_valid;
    logic                   out_ready;
    logic [2:0]             out_slot_v;
    logic [2:0][PTAG_W-1:0] prs1;
    logic [2:0][PTAG_W-1:0] prs2;
    logic [2:0][PTAG_W-1:0] prd;
    logic [2:0][PTAG_W-1:0] old_prd;

    logic [2:0]             cmt_we;
    logic [2:0][AREG_W-1:0] cmt_rd;
    logic [2:0][PTAG_W-1:0] cmt_prd;
    logic                   flush;

    modport master (
        output dec_valid, rs1, rs2, rd, rd_we, fl_count, alloc_tag, out_ready,
               cmt_we, cmt_rd, cmt_prd, flush,
        input  dec_ready, alloc_req, out_valid, out_slot_v, prs1, prs2, prd, old_prd
    );

    modport slave (
        input  dec_valid, rs1, rs2, rd, rd_we, fl_count, alloc_tag, out_ready,
               cmt_we, cmt_rd, cmt_prd, flush,
        output dec_ready, alloc_req, out_valid, out_slot_v, prs1, prs2, prd, old_prd
    );
endinterface

// File: rtl/rename_map_table_3way.sv
// 3-wide register rename: speculative RAT with in-group bypass, committed RAT for flush recovery.
// Optional macro RAT_X0_HARDWIRE_EN pins architectural x0 to physical tag 0.
module rename_map_table_3way #(
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    rename_map_table_3way_if.slave bus
);
    localparam int AREG_W = $clog2(ARCH_REGS);
    localparam int PTAG_W = $clog2(PHYS_REGS);

    logic [ARCH_REGS-1:0][PTAG_W-1:0] spec_rat_q, spec_rat_d;
    logic [ARCH_REGS-1:0][PTAG_W-1:0] cmt_rat_q, cmt_rat_d;

    logic                   out_valid_q, out_valid_d;
    logic [2:0]             out_slot_v_q, out_slot_v_d;
    logic [2:0][PTAG_W-1:0] prs1_q, prs1_d;
    logic [2:0][PTAG_W-1:0] prs2_q, prs2_d;
    logic [2:0][PTAG_W-1:0] prd_q, prd_d;
    logic [2:0][PTAG_W-1:0] old_prd_q, old_prd_d;

    logic [2:0]             needs;
    logic [1:0]             need;
    logic                   can_accept;
    logic                   fire;
    logic [2:0][PTAG_W-1:0] new_tag;
    logic [2:0][PTAG_W-1:0] look1, look2, look_old;

    always_comb begin
        needs = '0;
        for (int k = 0; k < 3; k++) begin
`ifdef RAT_X0_HARDWIRE_EN
            needs[k] = bus.dec_valid[k] & bus.rd_we[k] & (bus.rd[k] != '0);
`else
            needs[k] = bus.dec_valid[k] & bus.rd_we[k];
`endif
        end
        need       = 2'(needs[0]) + 2'(needs[1]) + 2'(needs[2]);
        can_accept = !out_valid_q | bus.out_ready;
        // Depends only on state and decode inputs, never on alloc_tag.
        fire       = (|bus.dec_valid) & can_accept & !bus.flush &
                     (bus.fl_count >= (PTAG_W+1)'(need));

        // Free-list data is compacted over requests: slot k takes the entry after all older needers.
        new_tag[0] = bus.alloc_tag[0];
        new_tag[1] = needs[0] ? bus.alloc_tag[1] : bus.alloc_tag[0];
        new_tag[2] = bus.alloc_tag[2'(needs[0]) + 2'(needs[1])];
    end

    always_comb begin
        look1    = '0;
        look2    = '0;
        look_old = '0;
        for (int k = 0; k < 3; k++) begin
            look1[k]    = spec_rat_q[bus.rs1[k]];
            look2[k]    = spec_rat_q[bus.rs2[k]];
            look_old[k] = spec_rat_q[bus.rd[k]];
            // Walking oldest to youngest lets the youngest older writer win.
            for (int j = 0; j < k; j++) begin
                if (needs[j]) begin
                    if (bus.rd[j] == bus.rs1[k]) look1[k]    = new_tag[j];
                    if (bus.rd[j] == bus.rs2[k]) look2[k]    = new_tag[j];
                    if (bus.rd[j] == bus.rd[k])  look_old[k] = new_tag[j];
                end
            end
`ifdef RAT_X0_HARDWIRE_EN
            if (bus.rs1[k] == '0) look1[k] = '0;
            if (bus.rs2[k] == '0) look2[k] = '0;
`endif
        end
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_slot_v_d = out_slot_v_q;
        prs1_d       = prs1_q;
        prs2_d       = prs2_q;
        prd_d        = prd_q;
        old_prd_d    = old_prd_q;
        if (fire) begin
            out_valid_d  = 1'b1;
            out_slot_v_d = bus.dec_valid;
            for (int k = 0; k < 3; k++) begin
                prs1_d[k]    = bus.dec_valid[k] ? look1[k] : '0;
                prs2_d[k]    = bus.dec_valid[k] ? look2[k] : '0;
                prd_d[k]     = needs[k] ? new_tag[k] : '0;
                old_prd_d[k] = needs[k] ? look_old[k] : '0;
            end
        end else if (bus.flush | bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        cmt_rat_d = cmt_rat_q;
        for (int k = 0; k < 3; k++) begin
`ifdef RAT_X0_HARDWIRE_EN
            if (bus.cmt_we[k] && bus.cmt_rd[k] != '0) cmt_rat_d[bus.cmt_rd[k]] = bus.cmt_prd[k];
`else
            if (bus.cmt_we[k]) cmt_rat_d[bus.cmt_rd[k]] = bus.cmt_prd[k];
`endif
        end

        spec_rat_d = spec_rat_q;
        // Recovery copies the committed map including this cycle's commits.
        if (bus.flush) begin
            spec_rat_d = cmt_rat_d;
        end else if (fire) begin
            for (int k = 0; k < 3; k++) begin
                if (needs[k]) spec_rat_d[bus.rd[k]] = new_tag[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                spec_rat_q[i] <= PTAG_W'(i);
                cmt_rat_q[i]  <= PTAG_W'(i);
            end
            out_valid_q  <= 1'b0;
            out_slot_v_q <= '0;
            prs1_q       <= '0;
            prs2_q       <= '0;
            prd_q        <= '0;
            old_prd_q    <= '0;
        end else begin
            spec_rat_q   <= spec_rat_d;
            cmt_rat_q    <= cmt_rat_d;
            out_valid_q  <= out_valid_d;
            out_slot_v_q <= out_slot_v_d;
            prs1_q       <= prs1_d;
            prs2_q       <= prs2_d;
            prd_q        <= prd_d;
            old_prd_q    <= old_prd_d;
        end
    end

    assign bus.dec_ready  = fire;
    assign bus.alloc_req  = fire ? needs : 3'b000;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_slot_v = out_slot_v_q;
    assign bus.prs1       = prs1_q;
    assign bus.prs2       = prs2_q;
    assign bus.prd        = prd_q;
    assign bus.old_prd    = old_prd_q;
endmodule

// File: tb/tb_rename_map_table_3way.sv
// Bench for rename_map_table_3way: directed scenarios then random groups against a sequential rename model.
// Define RAT_X0_HARDWIRE_EN for both bench and RTL to cover the hardwired-x0 build.
module tb_rename_map_table_3way;
    localparam int AR = 32;
    localparam int PR = 64;
`ifdef RAT_X0_HARDWIRE_EN
    localparam bit X0 = 1'b1;
`else
    localparam bit X0 = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    rename_map_table_3way_if #(.ARCH_REGS(AR), .PHYS_REGS(PR)) bus ();
    rename_map_table_3way #(.ARCH_REGS(AR), .PHYS_REGS(PR)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: architectural maps as plain integer arrays, group renamed slot by slot.
    int spec_m[AR];
    int cmt_m[AR];
    int tmp_m[AR];
    bit m_fire;
    logic [2:0] m_needs;
    bit m_out_valid;
    logic [2:0] m_slot_v;
    int m_prs1[3], m_prs2[3], m_prd[3], m_old[3];
    int n_prs1[3], n_prs2[3], n_prd[3], n_old[3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.dec_valid = '0;
        bus.rs1       = '0;
        bus.rs2       = '0;
        bus.rd        = '0;
        bus.rd_we     = '0;
        bus.fl_count  = 7'd32;
        bus.alloc_tag = '0;
        bus.out_ready = 1'b1;
        bus.cmt_we    = '0;
        bus.cmt_rd    = '0;
        bus.cmt_prd   = '0;
        bus.flush     = 1'b0;
    endtask

    task automatic set_slot(input int k, input int s1, input int s2, input int d, input int we);
        bus.dec_valid[k] = 1'b1;
        bus.rs1[k]       = 5'(s1);
        bus.rs2[k]       = 5'(s2);
        bus.rd[k]        = 5'(d);
        bus.rd_we[k]     = 1'(we);
    endtask

    task automatic model_comb();
        int used;
        int need;
        used = 0;
        need = 0;
        tmp_m = spec_m;
        m_needs = '0;
        for (int k = 0; k < 3; k++) begin
            m_needs[k] = bus.dec_valid[k] && bus.rd_we[k] && !(X0 && bus.rd[k] == 0);
            if (m_needs[k]) need++;
        end
        m_fire = (bus.dec_valid != 0) && (!m_out_valid || bus.out_ready) && !bus.flush &&
                 (int'(bus.fl_count) >= need);
        for (int k = 0; k < 3; k++) begin
            n_prs1[k] = 0; n_prs2[k] = 0; n_prd[k] = 0; n_old[k] = 0;
            if (bus.dec_valid[k]) begin
                n_prs1[k] = (X0 && bus.rs1[k] == 0) ? 0 : tmp_m[bus.rs1[k]];
                n_prs2[k] = (X0 && bus.rs2[k] == 0) ? 0 : tmp_m[bus.rs2[k]];
                if (m_needs[k]) begin
                    n_old[k] = tmp_m[bus.rd[k]];
                    n_prd[k] = int'(bus.alloc_tag[used]);
                    used++;
                    tmp_m[bus.rd[k]] = n_prd[k];
                end
            end
        end
    endtask

    task automatic model_seq();
        for (int k = 0; k < 3; k++)
            if (bus.cmt_we[k] && !(X0 && bus.cmt_rd[k] == 0)) cmt_m[bus.cmt_rd[k]] = int'(bus.cmt_prd[k]);
        if (bus.flush) begin
            spec_m = cmt_m;
            m_out_valid = 1'b0;
        end else if (m_fire) begin
            spec_m = tmp_m;
            m_out_valid = 1'b1;
            m_slot_v = bus.dec_valid;
            m_prs1 = n_prs1; m_prs2 = n_prs2; m_prd = n_prd; m_old = n_old;
        end else if (bus.out_ready) begin
            m_out_valid = 1'b0;
        end
    endtask

    task automatic check_out();
        check("out_valid", bus.out_valid, m_out_valid);
        if (m_out_valid) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("slot_v_%0d", k), bus.out_slot_v[k], m_slot_v[k]);
                check($sformatf("prs1_%0d", k), bus.prs1[k], m_prs1[k]);
                check($sformatf("prs2_%0d", k), bus.prs2[k], m_prs2[k]);
                check($sformatf("prd_%0d", k), bus.prd[k], m_prd[k]);
                check($sformatf("old_prd_%0d", k), bus.old_prd[k], m_old[k]);
            end
        end
    endtask

    // Inputs are set at a falling edge; combinational outputs are checked 1ns later,
    // registered outputs at the next falling edge.
    task automatic cycle();
        #1;
        model_comb();
        check("dec_ready", bus.dec_ready, m_fire);
        check("alloc_req", bus.alloc_req, m_fire ? m_needs : 3'b000);
        @(posedge clk);
        model_seq();
        @(negedge clk);
        check_out();
    endtask

    initial begin
        idle();
        for (int i = 0; i < AR; i++) begin
            spec_m[i] = i;
            cmt_m[i]  = i;
        end
        m_out_valid = 1'b0;
        m_slot_v = '0;
        #2 rst_n = 1'b0;
        #20;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_slot_v", bus.out_slot_v, 0);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_prs1_%0d", k), bus.prs1[k], 0);
            check($sformatf("rst_prs2_%0d", k), bus.prs2[k], 0);
            check($sformatf("rst_prd_%0d", k), bus.prd[k], 0);
            check($sformatf("rst_old_%0d", k), bus.old_prd[k], 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single source read, no writes.
        idle(); set_slot(0, 5, 0, 0, 0);
        cycle();
        check("t1_out_valid", bus.out_valid, 1);
        check("t1_prs1", bus.prs1[0], 5);
        idle(); cycle();

        // Full-width allocation.
        idle();
        set_slot(0, 0, 0, 1, 1); set_slot(1, 0, 0, 2, 1); set_slot(2, 0, 0, 3, 1);
        bus.alloc_tag[0] = 6'd32; bus.alloc_tag[1] = 6'd33; bus.alloc_tag[2] = 6'd34;
        cycle();
        for (int k = 0; k < 3; k++) begin
            check("t2_prd", bus.prd[k], 32 + k);
            check("t2_old_prd", bus.old_prd[k], 1 + k);
        end
        idle(); set_slot(0, 1, 2, 0, 0); set_slot(1, 3, 0, 0, 0);
        cycle();
        check("t2_rat1", bus.prs1[0], 32);
        check("t2_rat2", bus.prs2[0], 33);
        check("t2_rat3", bus.prs1[1], 34);

        // In-group dependency chain.
        idle();
        set_slot(0, 0, 0, 4, 1); set_slot(1, 4, 0, 4, 1); set_slot(2, 0, 4, 0, 0);
        bus.alloc_tag[0] = 6'd40; bus.alloc_tag[1] = 6'd41;
        cycle();
        check("t3_prs1_1", bus.prs1[1], 40);
        check("t3_old_prd_1", bus.old_prd[1], 40);
        check("t3_prs2_2", bus.prs2[2], 41);
        idle(); set_slot(0, 4, 0, 0, 0);
        cycle();
        check("t3_rat4", bus.prs1[0], 41);

        // Free list too short, then sufficient.
        idle(); set_slot(0, 0, 0, 5, 1); set_slot(1, 0, 0, 6, 1);
        bus.fl_count = 7'd1; bus.alloc_tag[0] = 6'd50; bus.alloc_tag[1] = 6'd51;
        #1;
        check("t4_stall_ready", bus.dec_ready, 0);
        check("t4_stall_alloc", bus.alloc_req, 0);
        cycle();
        bus.fl_count = 7'd2;
        cycle();
        check("t4_fire_valid", bus.out_valid, 1);
        check("t4_fire_prd1", bus.prd[1], 51);

        // Flush without and with a same-cycle commit.
        idle(); set_slot(0, 0, 0, 7, 1); bus.alloc_tag[0] = 6'd45; cycle();
        idle(); bus.flush = 1'b1; cycle();
        check("t5_flush_valid", bus.out_valid, 0);
        idle(); set_slot(0, 7, 0, 0, 0); cycle();
        check("t5_rat7_restored", bus.prs1[0], 7);
        idle(); set_slot(0, 0, 0, 7, 1); bus.alloc_tag[0] = 6'd45; cycle();
        idle(); bus.flush = 1'b1;
        bus.cmt_we[0] = 1'b1; bus.cmt_rd[0] = 5'd7; bus.cmt_prd[0] = 6'd45;
        cycle();
        idle(); set_slot(0, 7, 0, 0, 0); cycle();
        check("t5_rat7_committed", bus.prs1[0], 45);

        // Backpressure hold.
        idle(); cycle();
        idle(); bus.out_ready = 1'b0; set_slot(0, 9, 10, 11, 1); bus.alloc_tag[0] = 6'd55;
        cycle();
        for (int n = 0; n < 2; n++) begin
            cycle();
            check("t6_hold_valid", bus.out_valid, 1);
            check("t6_hold_prd", bus.prd[0], 55);
            check("t6_hold_ready", bus.dec_ready, 0);
        end
        idle(); cycle();

`ifdef RAT_X0_HARDWIRE_EN
        idle(); set_slot(0, 0, 0, 0, 1); bus.alloc_tag[0] = 6'd60;
        #1;
        check("t7_x0_alloc", bus.alloc_req, 0);
        cycle();
        check("t7_x0_prd", bus.prd[0], 0);
`endif

        for (int n = 0; n < 400; n++) begin
            int nv;
            idle();
            nv = $urandom_range(0, 3);
            for (int k = 0; k < nv; k++)
                set_slot(k, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                         $urandom_range(0, 1));
            for (int k = 0; k < 3; k++) begin
                bus.alloc_tag[k] = 6'($urandom_range(32, 63));
                bus.cmt_we[k]    = 1'($urandom_range(0, 1));
                bus.cmt_rd[k]    = 5'($urandom_range(0, 7));
                bus.cmt_prd[k]   = 6'($urandom_range(0, 63));
            end
            bus.fl_count  = 7'($urandom_range(0, 4));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.flush     = ($urandom_range(0, 15) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
